// File: rtl/fifo16x4.sv
// 16-word x 4-bit show-ahead FIFO with count, level flags and optional
// sticky overflow/underflow flags (enable with FIFO16X4_ERRFLAGS_EN).
//
// Ports:
//   CLK          clock, all state changes on rising edge
//   RESET        synchronous active-high reset
//   WRE, DI      write request and 4-bit write data
//   RDE          read request, pops the head word
//   DO           head word (valid while EMPTY=0)
//   CNT          stored word count 0..16
//   FULL, EMPTY  CNT==16 / CNT==0
//   ALMOST_FULL  CNT >= AF_LEVEL
//   ALMOST_EMPTY CNT <= AE_LEVEL
//   OVF, UDF     sticky error flags (constant 0 unless macro defined)
module fifo16x4 #(
  parameter logic [4:0] AF_LEVEL = 5'd12,
  parameter logic [4:0] AE_LEVEL = 5'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WRE,
  input  logic [3:0] DI,
  input  logic       RDE,
  output logic [3:0] DO,
  output logic [4:0] CNT,
  output logic       FULL,
  output logic       EMPTY,
  output logic       ALMOST_FULL,
  output logic       ALMOST_EMPTY,
  output logic       OVF,
  output logic       UDF
);

  logic [3:0] mem [16];
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [4:0] cnt;
  logic       wr_ok;
  logic       rd_ok;

  // Flags come from the registered count only.
  assign FULL         = (cnt == 5'd16);
  assign EMPTY        = (cnt == 5'd0);
  assign ALMOST_FULL  = (cnt >= AF_LEVEL);
  assign ALMOST_EMPTY = (cnt <= AE_LEVEL);
  assign CNT          = cnt;
  assign DO           = mem[rd_ptr];

  // A full FIFO still takes a write when a read frees a slot the same
  // edge; an empty FIFO never reads, so DI is not bypassed to DO.
  assign rd_ok = RDE && !EMPTY;
  assign wr_ok = WRE && (!FULL || RDE);

  always_ff @(posedge CLK) begin
    if (!RESET && wr_ok) begin
      mem[wr_ptr] <= DI;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      cnt    <= 5'd0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 4'd1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 4'd1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO16X4_ERRFLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WRE && FULL && !RDE) begin
        ovf_q <= 1'b1;
      end
      if (RDE && EMPTY) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`else
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule

// File: tb/tb_fifo16x4.sv
// Self-checking bench for fifo16x4: directed scenarios then random
// traffic, all outputs compared against a queue-based reference model.
module tb_fifo16x4;

  logic       CLK;
  logic       RESET;
  logic       WRE;
  logic [3:0] DI;
  logic       RDE;
  logic [3:0] DO;
  logic [4:0] CNT;
  logic       FULL;
  logic       EMPTY;
  logic       ALMOST_FULL;
  logic       ALMOST_EMPTY;
  logic       OVF;
  logic       UDF;

  int checks = 0;
  int errors = 0;

  logic [3:0] q[$];
  logic       m_ovf;
  logic       m_udf;

  fifo16x4 dut (
    .CLK(CLK),
    .RESET(RESET),
    .WRE(WRE),
    .DI(DI),
    .RDE(RDE),
    .DO(DO),
    .CNT(CNT),
    .FULL(FULL),
    .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY),
    .OVF(OVF),
    .UDF(UDF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, "_cnt"}, {3'b0, CNT}, 8'(n));
    check({tag, "_full"}, {7'b0, FULL}, {7'b0, n == 16});
    check({tag, "_empty"}, {7'b0, EMPTY}, {7'b0, n == 0});
    check({tag, "_af"}, {7'b0, ALMOST_FULL}, {7'b0, n >= 12});
    check({tag, "_ae"}, {7'b0, ALMOST_EMPTY}, {7'b0, n <= 4});
    check({tag, "_ovf"}, {7'b0, OVF}, {7'b0, m_ovf});
    check({tag, "_udf"}, {7'b0, UDF}, {7'b0, m_udf});
    if (n > 0) begin
      check({tag, "_do"}, {4'b0, DO}, {4'b0, q[0]});
    end
  endtask

  // One clock: drive inputs, advance the model, then compare.
  task automatic cyc(input string tag, input logic rst, input logic we,
                     input logic [3:0] d, input logic re);
    bit full;
    bit empty;
    RESET = rst;
    WRE   = we;
    DI    = d;
    RDE   = re;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full  = (q.size() == 16);
      empty = (q.size() == 0);
`ifdef FIFO16X4_ERRFLAGS_EN
      if (we && full && !re) m_ovf = 1'b1;
      if (re && empty) m_udf = 1'b1;
`endif
      if (re && !empty) void'(q.pop_front());
      if (we && (!full || re)) q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int wp;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    RESET = 1'b1;
    WRE = 1'b0;
    DI = 4'h0;
    RDE = 1'b0;

    cyc("rst", 1, 0, 4'h0, 0);
    cyc("rst2", 1, 1, 4'h9, 1);

    // Two writes, then one read.
    cyc("w_a", 0, 1, 4'hA, 0);
    cyc("w_5", 0, 1, 4'h5, 0);
    check("r34_do_a", {4'b0, DO}, 8'h0A);
    check("r34_cnt2", {3'b0, CNT}, 8'd2);
    cyc("rd1", 0, 0, 4'h0, 1);
    check("r34_do_5", {4'b0, DO}, 8'h05);
    cyc("rd2", 0, 0, 4'h0, 1);

    // Fill 0..F, then overflow attempt.
    cyc("rst3", 1, 0, 4'h0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc("fill", 0, 1, 4'(i), 0);
    end
    check("r35_full", {7'b0, FULL}, 8'd1);
    cyc("ovf", 0, 1, 4'hE, 0);
    check("r35_cnt16", {3'b0, CNT}, 8'd16);

    // Full with simultaneous read/write, then drain across the wrap.
    cyc("fullrw", 0, 1, 4'h7, 1);
    check("r36_cnt16", {3'b0, CNT}, 8'd16);
    for (int i = 0; i < 16; i++) begin
      cyc("drain", 0, 0, 4'h0, 1);
    end
    check("r36_empty", {7'b0, EMPTY}, 8'd1);

    // Empty with read+write, then underflow.
    cyc("emptyrw", 0, 1, 4'h3, 1);
    check("r37_do3", {4'b0, DO}, 8'h03);
    cyc("pop", 0, 0, 4'h0, 1);
    cyc("udf", 0, 0, 4'h0, 1);
    check("r37_cnt0", {3'b0, CNT}, 8'd0);

    // Reset mid-operation at CNT=9.
    for (int i = 0; i < 9; i++) begin
      cyc("fill9", 0, 1, 4'(i + 2), 0);
    end
    cyc("rst9", 1, 1, 4'hF, 0);
    check("r38_cnt0", {3'b0, CNT}, 8'd0);
    cyc("w_c", 0, 1, 4'hC, 0);
    check("r38_do_c", {4'b0, DO}, 8'h0C);

    // Random traffic in phases biased toward full, empty and balanced.
    for (int ph = 0; ph < 3; ph++) begin
      wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      for (int i = 0; i < 250; i++) begin
        cyc("rnd", ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < wp),
            4'($urandom),
            ($urandom_range(0, 99) < (100 - wp)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo16x4.md
FIFO16X4 -- requirements
Module: fifo16x4

Interface
REQ-001 SHALL have parameter AF_LEVEL, default 5'd12: ALMOST_FULL asserts when CNT >= AF_LEVEL (legal 1..16).
REQ-002 SHALL have parameter AE_LEVEL, default 5'd4: ALMOST_EMPTY asserts when CNT <= AE_LEVEL (legal 0..15).
REQ-003 SHALL have port CLK  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port WRE  input  1  write request; pushes DI.
REQ-006 SHALL have port DI  input  4  write data.
REQ-007 SHALL have port RDE  input  1  read request; pops the head word.
REQ-008 SHALL have port DO  output  4  head word, show-ahead; valid whenever EMPTY=0.
REQ-009 SHALL have port CNT  output  5  stored words, 0..16.
REQ-010 SHALL have port FULL  output  1  CNT == 16.
REQ-011 SHALL have port EMPTY  output  1  CNT == 0.
REQ-012 SHALL have port ALMOST_FULL  output  1  CNT >= AF_LEVEL.
REQ-013 SHALL have port ALMOST_EMPTY  output  1  CNT <= AE_LEVEL.
REQ-014 SHALL have port OVF  output  1  sticky overflow flag (see Configuration).
REQ-015 SHALL have port UDF  output  1  sticky underflow flag (see Configuration).

Function
REQ-016 SHALL store 16 words x 4 bits in a single array with one write port and one asynchronous read port at the read pointer.
REQ-017 SHALL keep 4-bit write and read pointers that wrap from 15 to 0 with no extra logic.
REQ-018 SHALL accept a write when WRE=1 and (FULL=0 or RDE=1); the word lands at the write pointer and the pointer increments.
REQ-019 SHALL accept a read when RDE=1 and EMPTY=0; the read pointer increments.
REQ-020 SHALL, on simultaneous accepted write and read, leave CNT unchanged; when full, both SHALL be accepted.
REQ-021 SHALL, with RDE=1 and WRE=1 while empty, accept only the write; no bypass of DI to DO.
REQ-022 SHALL update CNT by +1 on write-only, -1 on read-only, and 0 otherwise.
REQ-023 SHALL derive FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY from the registered CNT only, with no combinational path from WRE, RDE or DI.
REQ-024 SHALL make a word written into an empty FIFO visible on DO, with EMPTY=0, in the cycle after the write edge (latency 1).
REQ-025 SHALL, after a read, show the next word on DO in the cycle after the read edge.
REQ-026 SHALL ignore a write when full without a read, and a read when empty, with pointers, CNT and memory unchanged.

Reset
REQ-027 SHALL, on RESET=1 at a clock edge, set both pointers=0, CNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0, ALMOST_EMPTY=1, OVF=0, UDF=0.
REQ-028 SHALL give RESET priority over WRE and RDE in the same cycle; neither write is stored nor read accepted.
REQ-029 SHALL not clear memory contents on reset; DO value is don't-care while EMPTY=1.
REQ-030 SHALL, on reset mid-operation, discard all stored words; the next write appears at address 0.

Configuration
REQ-031 SHALL, with macro FIFO16X4_ERRFLAGS_EN defined, set OVF sticky on any cycle with WRE=1, FULL=1, RDE=0.
REQ-032 SHALL, with FIFO16X4_ERRFLAGS_EN defined, set UDF sticky on any cycle with RDE=1, EMPTY=1; both flags clear only on RESET.
REQ-033 SHALL, without FIFO16X4_ERRFLAGS_EN, drive OVF and UDF constant 0 and implement no flag registers; the port list is identical in both builds.

Verification
REQ-034 SHALL cover: reset, then write 4'hA, 4'h5 on consecutive cycles -> next cycle DO=4'hA, CNT=2, EMPTY=0; after one read, DO=4'h5, CNT=1.
REQ-035 SHALL cover: write 16 words 0..F from empty -> FULL=1, CNT=16, ALMOST_FULL=1 from CNT=12; a 17th write with RDE=0 is dropped, and with the macro OVF=1.
REQ-036 SHALL cover: full FIFO, WRE=1, RDE=1, DI=4'h7 -> CNT stays 16; reading all out yields 1..F then 7, exercising pointer wrap.
REQ-037 SHALL cover: empty FIFO, WRE=1, RDE=1, DI=4'h3 -> CNT=1, DO=4'h3 next cycle; RDE alone while empty -> CNT=0, UDF=1 with the macro, 0 without.
REQ-038 SHALL cover: CNT=9, RESET=1 with WRE=1 -> CNT=0, EMPTY=1, OVF=UDF=0; next write DI=4'hC -> DO=4'hC.
